// File: rtl/gpio_mmio_responder.sv
// gpio_mmio_responder
//
// Memory-mapped GPIO block for the CPU data-memory bus. It answers loads and
// stores that fall inside a 16-byte window starting at BASE.
//
// Register map, selected by Address_i[3:2]. Address_i[1:0] is ignored.
//   0x0 OUT  RW    drives GPIO_o[7:0]
//   0x4 IN   RO    debounced input value
//   0x8 EDGE RW1C  sticky rising-edge flags
//   0xC MASK RW    interrupt mask for EDGE
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   Write_Enable_i store strobe from the CPU
//   Address_i      byte address from the CPU
//   Write_Data     store data (only bits [7:0] are used)
//   Read_Data      combinational load data; 0 when outside the window
//   hit_o          address falls inside the window
//   GPIO_i         asynchronous input pins
//   GPIO_o         output pins, equal to the OUT register
//   irq_o          level interrupt, |(EDGE & MASK)
//
// Bus semantics: there is no handshake. Every cycle is a potential access.
// A store commits at the rising edge while Write_Enable_i && hit_o is high.
// A load is answered combinationally in the same cycle, and the CPU latches
// Read_Data at the next edge.
module gpio_mmio_responder #(
  parameter logic [31:0] BASE     = 32'h1001_0100,
  parameter int          DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Write_Enable_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        hit_o,
  input  logic [7:0]  GPIO_i,
  output logic [7:0]  GPIO_o,
  output logic        irq_o
);

  localparam int              CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE - 1);

  localparam logic [1:0] OFS_OUT  = 2'd0;
  localparam logic [1:0] OFS_IN   = 2'd1;
  localparam logic [1:0] OFS_EDGE = 2'd2;
  localparam logic [1:0] OFS_MASK = 2'd3;

  logic [7:0]    out_q;
  logic [7:0]    edge_q;
  logic [7:0]    mask_q;
  logic [7:0]    s1_q;
  logic [7:0]    s2_q;
  logic [7:0]    cand_q;
  logic [7:0]    deb_q;
  logic [CW-1:0] cnt_q;

  logic       wr;
  logic [1:0] sel;
  logic       deb_load;
  logic [7:0] edge_clr;
  logic [7:0] edge_set;

  // Byte-lane and upper write-data bits are intentionally not decoded.
  logic unused_bits;
  assign unused_bits = &{1'b0, Address_i[1:0], Write_Data[31:8]};

  assign hit_o = (Address_i[31:4] == BASE[31:4]);
  assign sel   = Address_i[3:2];
  assign wr    = Write_Enable_i && hit_o;

  // deb accepts cand only after cand has matched s2 for DEBOUNCE cycles.
  assign deb_load = (s2_q == cand_q) && (cand_q != deb_q) && (cnt_q == CNT_MAX);

  assign edge_clr = (wr && (sel == OFS_EDGE)) ? Write_Data[7:0] : 8'h00;
  assign edge_set = deb_load ? (cand_q & ~deb_q) : 8'h00;

  // Input path: two-flop synchronizer, then the debounce qualifier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 8'h00;
      s2_q   <= 8'h00;
      cand_q <= 8'h00;
      deb_q  <= 8'h00;
      cnt_q  <= '0;
    end else begin
      s1_q <= GPIO_i;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (cand_q != deb_q) begin
        if (cnt_q == CNT_MAX) begin
          deb_q <= cand_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Register file. EDGE applies the W1C clear first and then ORs in new
  // rising edges, so a set that collides with a clear on the same bit wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= 8'h00;
      edge_q <= 8'h00;
      mask_q <= 8'h00;
    end else begin
      if (wr && (sel == OFS_OUT))  out_q  <= Write_Data[7:0];
      if (wr && (sel == OFS_MASK)) mask_q <= Write_Data[7:0];
      edge_q <= (edge_q & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    Read_Data = 32'h0;
    if (hit_o) begin
      case (sel)
        OFS_OUT:  Read_Data = {24'h0, out_q};
        OFS_IN:   Read_Data = {24'h0, deb_q};
        OFS_EDGE: Read_Data = {24'h0, edge_q};
        OFS_MASK: Read_Data = {24'h0, mask_q};
        default:  Read_Data = 32'h0;
      endcase
    end
  end

  assign GPIO_o = out_q;
  assign irq_o  = |(edge_q & mask_q);

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// Directed testbench for gpio_mmio_responder with DEBOUNCE = 4.
// Inputs are changed 1 time unit after a rising edge. Outputs are sampled in
// the same window, away from the active edge.
module tb_gpio_mmio_responder;

  localparam logic [31:0] A_OUT  = 32'h1001_0100;
  localparam logic [31:0] A_IN   = 32'h1001_0104;
  localparam logic [31:0] A_EDGE = 32'h1001_0108;
  localparam logic [31:0] A_MASK = 32'h1001_010C;

  logic        clk;
  logic        reset;
  logic        Write_Enable_i;
  logic [31:0] Address_i;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;
  logic        hit_o;
  logic [7:0]  GPIO_i;
  logic [7:0]  GPIO_o;
  logic        irq_o;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  gpio_mmio_responder #(.BASE(32'h1001_0100), .DEBOUNCE(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .Write_Enable_i (Write_Enable_i),
    .Address_i      (Address_i),
    .Write_Data     (Write_Data),
    .Read_Data      (Read_Data),
    .hit_o          (hit_o),
    .GPIO_i         (GPIO_i),
    .GPIO_o         (GPIO_o),
    .irq_o          (irq_o)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drivers.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    Address_i      = a;
    Write_Data     = d;
    Write_Enable_i = 1'b1;
    tick();
    Write_Enable_i = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    Write_Enable_i = 1'b0;
    Address_i      = a;
    #1;
    d = Read_Data;
  endtask

  // Scoreboard: queue the expected load value, then compare it with the load.
  task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    exp_q.push_back(exp);
    do_read(a, d);
    check(tag, d, exp_q.pop_front());
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    Write_Enable_i = 1'b0;
    Address_i      = 32'h0;
    Write_Data     = 32'h0;
    GPIO_i         = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset defaults.
    check("rst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    read_expect("rst_out", A_OUT, 32'h0);
    read_expect("rst_in", A_IN, 32'h0);
    read_expect("rst_edge", A_EDGE, 32'h0);
    read_expect("rst_mask", A_MASK, 32'h0);

    // OUT write and readback; out-of-window store is ignored.
    do_write(A_OUT, 32'hDEAD_BEA5);
    check("out_gpio_o", {24'h0, GPIO_o}, 32'h0000_00A5);
    read_expect("out_read", A_OUT, 32'h0000_00A5);
    read_expect("out_read_byte3", 32'h1001_0103, 32'h0000_00A5);
    Address_i = 32'h1001_0110;
    #1;
    check("miss_hit", {31'h0, hit_o}, 32'h0);
    check("miss_read", Read_Data, 32'h0);
    do_write(32'h1001_0110, 32'h1234_5678);
    check("miss_gpio_o", {24'h0, GPIO_o}, 32'h0000_00A5);
    Address_i = A_OUT;
    #1;
    check("in_hit", {31'h0, hit_o}, 32'h1);

    // MASK write; IN is read-only.
    do_write(A_MASK, 32'hFFFF_FF01);
    read_expect("mask_read", A_MASK, 32'h1);
    do_write(A_IN, 32'h55);
    read_expect("in_ro", A_IN, 32'h0);

    // Debounce latency: 0x00 -> 0x81 appears at edge 7, not edge 6.
    GPIO_i = 8'h81;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) begin
        read_expect("deb_in_e6", A_IN, 32'h0);
        read_expect("deb_edge_e6", A_EDGE, 32'h0);
        check("deb_irq_e6", {31'h0, irq_o}, 32'h0);
      end
      if (e == 7) begin
        read_expect("deb_in_e7", A_IN, 32'h81);
        read_expect("deb_edge_e7", A_EDGE, 32'h81);
        check("deb_irq_e7", {31'h0, irq_o}, 32'h1);
      end
    end

    // W1C clears only the bits written as 1.
    do_write(A_EDGE, 32'h01);
    read_expect("w1c_edge", A_EDGE, 32'h80);
    check("w1c_irq", {31'h0, irq_o}, 32'h0);

    // A falling edge never sets EDGE.
    GPIO_i = 8'h80;
    for (int e = 1; e <= 8; e++) tick();
    read_expect("fall_in", A_IN, 32'h80);
    read_expect("fall_edge", A_EDGE, 32'h80);

    // Collision: the W1C of bit 0 commits on the same edge that sets bit 0.
    GPIO_i = 8'h81;
    for (int e = 1; e <= 6; e++) tick();
    do_write(A_EDGE, 32'h01);
    read_expect("coll_in", A_IN, 32'h81);
    read_expect("coll_edge", A_EDGE, 32'h81);
    check("coll_irq", {31'h0, irq_o}, 32'h1);

    // Glitch: GPIO_i[3] is high for 3 cycles and never reaches IN or EDGE.
    do_write(A_EDGE, 32'hFF);
    read_expect("clr_all_edge", A_EDGE, 32'h0);
    check("clr_all_irq", {31'h0, irq_o}, 32'h0);
    GPIO_i = 8'h89;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 3) GPIO_i = 8'h81;
      read_expect($sformatf("glitch_in_%0d", e), A_IN, 32'h81);
      read_expect($sformatf("glitch_edge_%0d", e), A_EDGE, 32'h0);
    end

    // Reset mid-count discards the pending change.
    GPIO_i = 8'hFF;
    for (int e = 1; e <= 4; e++) tick();
    reset = 1'b1;
    #1;
    check("mrst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    check("mrst_irq", {31'h0, irq_o}, 32'h0);
    read_expect("mrst_out", A_OUT, 32'h0);
    read_expect("mrst_in", A_IN, 32'h0);
    read_expect("mrst_edge", A_EDGE, 32'h0);
    read_expect("mrst_mask", A_MASK, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) read_expect("mrst_in_e6", A_IN, 32'h0);
      if (e == 7) begin
        read_expect("mrst_in_e7", A_IN, 32'hFF);
        read_expect("mrst_edge_e7", A_EDGE, 32'hFF);
        check("mrst_irq_e7", {31'h0, irq_o}, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
